// File: rtl/data_bus_initiator_pkg.sv
// Shared constants for the data bus initiator: RV32I load/store funct3 encodings
// and the access-size decode used by both the request encoder and the response aligner.
package data_bus_initiator_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } access_size_e;

    // funct3[2] only selects zero-extension on loads, so size lives in the low two bits.
    function automatic access_size_e size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SIZE_BYTE;
            2'b01:   return SIZE_HALF;
            default: return SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/data_bus_initiator_load_tag_fifo.sv
// Synchronous FIFO holding per-load metadata between bus issue and bus response.
// A push into a full FIFO is honoured only when a pop happens in the same cycle.
module load_tag_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once count says they were written.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/data_bus_initiator.sv
// Core-side data bus initiator: encodes load/store requests onto the bus with zero added
// latency, tracks outstanding loads in order, and aligns/extends returned load data.
module data_bus_initiator
    import data_bus_initiator_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TAG_WIDTH       = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_address,
    input  logic [31:0]          req_store_data,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic                 resp_valid,
    output logic [31:0]          resp_data,
    output logic [TAG_WIDTH-1:0] resp_tag,
    output logic                 misaligned,
    output logic                 protocol_error,
    output logic [31:0]          bus_address,
    output logic [31:0]          bus_write_data,
    output logic [3:0]           bus_byte_enable,
    output logic                 bus_read_enable,
    output logic                 bus_write_enable,
    input  logic                 bus_wait_req,
    input  logic [31:0]          bus_read_data,
    input  logic                 bus_valid
);

    localparam int META_W = TAG_WIDTH + 3 + 2;
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;

    access_size_e         req_size;
    logic [1:0]           req_off;
    logic                 addr_misaligned;
    logic                 fifo_full;
    logic                 fifo_at_capacity;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic                 load_push;
    logic                 resp_fire;
    logic [META_W-1:0]    fifo_head;
    logic [TAG_WIDTH-1:0] head_tag;
    logic [2:0]           head_funct3;
    logic [1:0]           head_off;
    logic [31:0]          shifted;
    logic                 protocol_error_q, protocol_error_d;

    assign req_size = size_of(req_funct3);
    assign req_off  = req_address[1:0];

    always_comb begin
        addr_misaligned = 1'b0;
        bus_byte_enable = 4'b1111;
        bus_write_data  = req_store_data;
        case (req_size)
            SIZE_BYTE: begin
                bus_byte_enable = 4'b0001 << req_off;
                bus_write_data  = {4{req_store_data[7:0]}};
            end
            SIZE_HALF: begin
                addr_misaligned = req_off[0];
                bus_byte_enable = req_off[1] ? 4'b1100 : 4'b0011;
                bus_write_data  = {2{req_store_data[15:0]}};
            end
            default: begin
                addr_misaligned = (req_off != 2'b00);
            end
        endcase
    end

    // A pop in this cycle frees a slot, so a load may issue into a FIFO that looks full.
    assign fifo_full        = fifo_at_capacity && !bus_valid;
    assign misaligned       = req_valid && addr_misaligned;
    assign bus_address      = {req_address[31:2], 2'b00};
    assign bus_read_enable  = req_valid && !req_write && !misaligned && !fifo_full;
    assign bus_write_enable = req_valid && req_write && !misaligned;
    assign req_ready        = misaligned || (!bus_wait_req && (req_write || !fifo_full));
    assign load_push        = bus_read_enable && !bus_wait_req;
    assign resp_fire        = bus_valid && (fifo_count != '0);

    load_tag_fifo #(
        .WIDTH (META_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_load_tag_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (load_push),
        .push_data ({req_tag, req_funct3, req_off}),
        .pop       (resp_fire),
        .pop_data  (fifo_head),
        .full      (fifo_at_capacity),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head_tag    = fifo_head[META_W-1 -: TAG_WIDTH];
    assign head_funct3 = fifo_head[4:2];
    assign head_off    = fifo_head[1:0];
    assign shifted     = bus_read_data >> {head_off, 3'b000};

    always_comb begin
        resp_data = shifted;
        case (size_of(head_funct3))
            SIZE_BYTE: resp_data = {{24{!head_funct3[2] && shifted[7]}}, shifted[7:0]};
            SIZE_HALF: resp_data = {{16{!head_funct3[2] && shifted[15]}}, shifted[15:0]};
            default:   resp_data = shifted;
        endcase
    end

    assign resp_valid = resp_fire;
    assign resp_tag   = head_tag;

    // A response with nothing outstanding means the responder and initiator disagree; latch it.
    always_comb begin
        protocol_error_d = protocol_error_q || (bus_valid && fifo_empty);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) protocol_error_q <= 1'b0;
        else       protocol_error_q <= protocol_error_d;
    end

    assign protocol_error = protocol_error_q;

endmodule
